modport_ahb_sram: RTL and testbench
===================================

// Module: modport_ahb_sram
// PURPOSE
// - AHB-Lite slave wrapping a 64 KB byte-addressable SRAM. Sits on the system AHB bus behind the decoder (hsel).
// - Zero-wait-state reads and writes; byte, halfword and word transfers with lane steering.
// - Drives OKAY responses, plus an optional two-cycle ERROR response for misaligned transfers.
// PARAMETERS
// - ADDR_WIDTH  16     byte address width; memory = 2**ADDR_WIDTH bytes
// - DATA_WIDTH  32     bus data width; only 32 is supported
// PORTS
// - hclk       in   1   bus clock; all state on rising edge
// - hresetn    in   1   asynchronous active-low reset
// - hsel       in   1   slave select from decoder
// - haddr      in   16  byte address (address phase)
// - htrans     in   2   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
// - hwrite     in   1   1 = write, 0 = read
// - hsize      in   3   0 byte, 1 halfword, 2 word; >2 treated as word
// - hready     in   1   bus-level ready (previous transfer complete)
// - hwdata     in   32  write data (data phase)
// - hrdata     out  32  read data (data phase)
// - hreadyout  out  1   slave ready
// - hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
// - Address phase accepted when hsel && hready && htrans[1]. Register addr, write, size and valid flag. IDLE and BUSY are not accepted.
// - Write data phase: on the next rising edge, write hwdata byte lanes into the array. Lanes are selected by size and addr[1:0]:
//   - byte: lane addr[1:0]
//   - half: lanes {addr[1],0} and {addr[1],1}
//   - word: all four lanes
// - Read data phase: hrdata = full 32-bit word at {addr[15:2],2'b00}, combinational from the array. The master picks the lanes.
//   - With no read data phase active, hrdata = 0.
// - Latency: 0 wait states; hreadyout = 1 for OKAY transfers.
// - Back-to-back write then read of the same address returns the new data. The write commits at the edge that starts the read data phase.
// - Response after an IDLE/BUSY or unselected address phase: hresp = 0, hreadyout = 1.
// - Reset (async): valid flag = 0, hreadyout = 1, hresp = 0, hrdata = 0. Array contents are not reset.
// - Reset asserted mid-transfer aborts the transfer. A pending write is dropped.
// - Address wrap: haddr uses all 16 bits, so there is no out-of-range case.
// CONFIGURATION
// - Macro AHB_SRAM_ERR_RESP_EN.
// - Defined: an accepted transfer is misaligned if (size==1 && addr[0]) or (size>=2 && addr[1:0]!=0).
//   - Data phase cycle 1: hresp = 1, hreadyout = 0.
//   - Cycle 2: hresp = 1, hreadyout = 1.
//   - Then hresp = 0.
//   - The array is not written and hrdata = 0.
//   - During cycle 1 no new address phase is accepted, because hready is low.
// - Not defined: low address bits below the transfer size are ignored (access forced aligned), hresp is tied 0, and hreadyout is tied 1.
// STRUCTURE
// - Package ahb_sram_pkg holds:
//   - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
//   - size constants SZ_BYTE/SZ_HALF/SZ_WORD
//   - RESP_OKAY/RESP_ERROR
//   - function byte_strobe(size, addr[1:0]) returning a 4-bit lane enable
// - Sub-module ahb_sram_mem: 2**(ADDR_WIDTH-2) x 32 array with 4-bit byte-write enable, synchronous write and asynchronous read.
// - Top holds the address-phase registers, the error FSM (OKAY, ERR1, ERR2) and the output muxing.
// TESTING
// - Word write then read: write 0xDEADBEEF @0x0010, then read @0x0010 -> hrdata = 0xDEADBEEF, hresp = 0, hreadyout = 1 throughout.
// - Byte lanes: word 0x00000000 @0x0020, then byte write 0xAA @0x0022 (hwdata = 0x00AA0000) -> read @0x0020 = 0x00AA0000.
// - Halfword: write 0x1234 @0x0032 (hwdata = 0x12340000) onto 0xFFFFFFFF -> read @0x0030 = 0x1234FFFF.
// - IDLE/unselected: htrans = 0 or hsel = 0 with hwrite = 1 and hwdata = 0x55 -> memory unchanged, next-cycle hresp = 0.
// - Misaligned word @0x0041:
//   - with AHB_SRAM_ERR_RESP_EN: hresp 1,1 then 0; hreadyout 0,1; memory unchanged.
//   - without the macro: write lands at 0x0040 with OKAY.
// - Reset: assert hresetn = 0 during a write data phase -> outputs go to hreadyout = 1, hresp = 0, hrdata = 0 immediately, and the write is not committed.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM slave: transfer encodings,
// response codes, error-FSM states and the byte-lane strobe decoder.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StOkay = 2'd0,
    StErr1 = 2'd1,
    StErr2 = 2'd2
  } err_state_e;

  // Sizes above a word act as a word; low address bits below the size are ignored.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr;
      SZ_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
    return ((size == SZ_HALF) && addr[0]) || ((size >= SZ_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array with per-byte write enables, synchronous write and
// asynchronous read. Contents are not reset.
module ahb_sram_mem #(
  parameter int unsigned AddrWidth = 14
) (
  input  logic                 clk_i,
  input  logic [3:0]           we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/modport_ahb_sram.sv
// Zero-wait-state AHB-Lite SRAM slave. Define AHB_SRAM_ERR_RESP_EN to answer
// misaligned transfers with a two-cycle ERROR instead of forcing alignment.
module modport_ahb_sram
  import ahb_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic                  valid_q, valid_d;
  logic                  trans_active;
  logic                  accept;
  logic [3:0]            mem_we;
  logic [31:0]           mem_rdata;

  assign trans_active = (htrans == TransNonseq) || (htrans == TransSeq);

`ifdef AHB_SRAM_ERR_RESP_EN
  err_state_e state_q, state_d;
  logic       misaligned;

  // hready is low in ERR1; the state check keeps a miswired bus from slipping a phase in.
  assign accept     = hsel && hready && trans_active && (state_q != StErr1);
  assign misaligned = accept && is_misaligned(hsize, haddr[1:0]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOkay:  state_d = misaligned ? StErr1 : StOkay;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = misaligned ? StErr1 : StOkay;
      default: state_d = StOkay;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StOkay;
    end else begin
      state_q <= state_d;
    end
  end

  assign hreadyout = (state_q != StErr1);
  assign hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? RESP_ERROR : RESP_OKAY;
`else
  assign accept    = hsel && hready && trans_active;
  assign hreadyout = 1'b1;
  assign hresp     = RESP_OKAY;
`endif

  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (accept) begin
      addr_d  = haddr;
      size_d  = hsize;
      write_d = hwrite;
    end
`ifdef AHB_SRAM_ERR_RESP_EN
    valid_d = accept && !misaligned;
`else
    valid_d = accept;
`endif
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      valid_q <= valid_d;
    end
  end

  // Write enables come from reset flops, so an async reset drops a pending write.
  assign mem_we = (valid_q && write_q) ? byte_strobe(size_q, addr_q[1:0]) : 4'b0000;

  ahb_sram_mem #(
    .AddrWidth(ADDR_WIDTH - 2)
  ) u_mem (
    .clk_i   (hclk),
    .we_i    (mem_we),
    .waddr_i (addr_q[ADDR_WIDTH-1:2]),
    .wdata_i (hwdata),
    .raddr_i (addr_q[ADDR_WIDTH-1:2]),
    .rdata_o (mem_rdata)
  );

  assign hrdata = (valid_q && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_modport_ahb_sram.sv
// Scoreboard bench for modport_ahb_sram: the driver queues the expected
// data-phase response per cycle, a negedge monitor pops and compares.
module tb_modport_ahb_sram;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic        resp;
    logic        rdy;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          passes = 0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  assign hready = hreadyout;

  modport_ahb_sram dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hready    (hready),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  // Monitor: compare every expectation whose data-phase cycle has arrived.
  always @(negedge hclk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || hrdata !== e.rd || hresp !== e.resp || hreadyout !== e.rdy) begin
        $display("FAIL %s: cyc=%0d hrdata=%h hresp=%b hreadyout=%b, expected cyc=%0d %h %b %b",
                 e.nm, cyc, hrdata, hresp, hreadyout, e.cyc, e.rd, e.resp, e.rdy);
      end else begin
        passes++;
      end
    end
  end

  function automatic void push(input string nm, input int unsigned c, input logic [31:0] rd,
                               input logic resp, input logic rdy);
    exp_t e;
    e.cyc = c; e.rd = rd; e.resp = resp; e.rdy = rdy; e.nm = nm;
    sb.push_back(e);
  endfunction

  // Address phase now; data phase (hwdata) after the next edge.
  task automatic issue(input string nm, input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic err);
    if (err) begin
      push({nm, "_c1"}, cyc + 1, 32'h0, 1'b1, 1'b0);
      push({nm, "_c2"}, cyc + 2, 32'h0, 1'b1, 1'b1);
    end else begin
      push(nm, cyc + 1, exp_rd, 1'b0, 1'b1);
    end
    hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a;
    @(posedge hclk);
    #1;
    hwdata = wd;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [2:0] sz, input logic [15:0] a,
                    input logic [31:0] wd);
    issue(nm, 1'b1, 2'b10, 1'b1, sz, a, wd, 32'h0, 1'b0);
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [31:0] exp_rd);
    issue(nm, 1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0, exp_rd, 1'b0);
  endtask

  initial begin
    hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; haddr = 16'h0; hwdata = 32'h0;
    @(posedge hclk);
    #1;
    issue("rst_state", 1'b1, 2'b10, 1'b0, 3'd2, 16'h0010, 32'h0, 32'h0, 1'b0);
    hresetn = 1'b1;
    issue("idle_after_rst", 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 32'h0, 32'h0, 1'b0);

    wr("w_word", 3'd2, 16'h0010, 32'hDEAD_BEEF);
    rd("r_word", 16'h0010, 32'hDEAD_BEEF);

    wr("w_zero", 3'd2, 16'h0020, 32'h0000_0000);
    wr("w_byte2", 3'd0, 16'h0022, 32'h00AA_0000);
    rd("r_byte2", 16'h0020, 32'h00AA_0000);
    wr("w_byte3", 3'd0, 16'h0023, 32'hBB00_0000);
    rd("r_byte3", 16'h0020, 32'hBBAA_0000);

    wr("w_ones", 3'd2, 16'h0030, 32'hFFFF_FFFF);
    wr("w_half", 3'd1, 16'h0032, 32'h1234_0000);
    rd("r_half", 16'h0030, 32'h1234_FFFF);

    wr("w_base", 3'd2, 16'h0060, 32'h0BAD_F00D);
    issue("idle_wr", 1'b1, 2'b00, 1'b1, 3'd2, 16'h0060, 32'h0000_0055, 32'h0, 1'b0);
    issue("unsel_wr", 1'b0, 2'b10, 1'b1, 3'd2, 16'h0060, 32'h0000_0055, 32'h0, 1'b0);
    rd("r_unchanged", 16'h0060, 32'h0BAD_F00D);

    wr("w_mis_base", 3'd2, 16'h0040, 32'h0102_0304);
`ifdef AHB_SRAM_ERR_RESP_EN
    issue("mis_word", 1'b1, 2'b10, 1'b1, 3'd2, 16'h0041, 32'h9999_9999, 32'h0, 1'b1);
    @(posedge hclk);
    #1;
    rd("r_mis", 16'h0040, 32'h0102_0304);
`else
    wr("mis_word", 3'd2, 16'h0041, 32'h9999_9999);
    rd("r_mis", 16'h0040, 32'h9999_9999);
`endif

    wr("w_rst_base", 3'd2, 16'h0050, 32'h5A5A_5A5A);
    // Reset during a read data phase must zero hrdata at once.
    rd("r_during_rst", 16'h0010, 32'h0);
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if (hrdata !== 32'h0) begin
      $display("FAIL rst_rd_hrdata: hrdata=%h, expected 0", hrdata);
    end else begin
      passes++;
    end
    checks++;
    if (hresp !== 1'b0) begin
      $display("FAIL rst_rd_hresp: hresp=%b, expected 0", hresp);
    end else begin
      passes++;
    end
    checks++;
    if (hreadyout !== 1'b1) begin
      $display("FAIL rst_rd_hreadyout: hreadyout=%b, expected 1", hreadyout);
    end else begin
      passes++;
    end
    @(posedge hclk);
    #1 hresetn = 1'b1;
    // Reset during a write data phase must drop the write.
    wr("w_during_rst", 3'd2, 16'h0050, 32'hCAFE_F00D);
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if (hrdata !== 32'h0) begin
      $display("FAIL rst_wr_hrdata: hrdata=%h, expected 0", hrdata);
    end else begin
      passes++;
    end
    checks++;
    if (hresp !== 1'b0) begin
      $display("FAIL rst_wr_hresp: hresp=%b, expected 0", hresp);
    end else begin
      passes++;
    end
    checks++;
    if (hreadyout !== 1'b1) begin
      $display("FAIL rst_wr_hreadyout: hreadyout=%b, expected 1", hreadyout);
    end else begin
      passes++;
    end
    @(posedge hclk);
    #1 hresetn = 1'b1;
    rd("r_after_rst", 16'h0050, 32'h5A5A_5A5A);
    rd("r_word_again", 16'h0010, 32'hDEAD_BEEF);
    issue("tail_idle", 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (sb.size() == 0) break;
      @(posedge hclk);
    end
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: no response observed, expected %h %b %b", e.nm, e.rd, e.resp, e.rdy);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
